aurora_hls_tx_framer: RTL and testbench

AURORA_HLS_TX_FRAMER -- requirements
Module: aurora_hls_tx_framer

---
 rtl/aurora_hls_pkg.sv | 13 +
 rtl/aurora_hls_tx_framer_if.sv | 18 +
 rtl/aurora_hls_keep_gen.sv | 38 +++
 rtl/aurora_hls_tx_framer.sv | 159 +++++++++++++++
 tb/tb_aurora_hls_tx_framer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aurora_hls_pkg.sv
// Shared definitions for the Aurora HLS TX framer: state encoding and default widths.
package aurora_hls_pkg;

   localparam int DATA_BYTES_DEF = 64;
   localparam int LEN_W_DEF      = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/aurora_hls_tx_framer_if.sv
// AXI-Stream style bundle used for both the framer input and the TX FIFO output.
interface aurora_hls_tx_framer_if
   import aurora_hls_pkg::*;
#(
   parameter int DATA_BYTES = DATA_BYTES_DEF
) ();

   logic [DATA_BYTES*8-1:0] tdata;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [DATA_BYTES-1:0]   tkeep;

   modport master (output tdata, output tvalid, input tready, output tlast, output tkeep);
   // The input side of the framer carries no framing of its own.
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/aurora_hls_keep_gen.sv
// Per-beat byte count, thermometer tkeep and tlast decision from the remaining counts.
module aurora_hls_keep_gen
   import aurora_hls_pkg::*;
#(
   parameter int DATA_BYTES = DATA_BYTES_DEF,
   parameter int LEN_W      = LEN_W_DEF
) (
   input  logic [LEN_W-1:0]      total_rem_i,
   input  logic [LEN_W-1:0]      frame_rem_i,
   input  logic                  frame_en_i,
   output logic [LEN_W-1:0]      n_o,
   output logic [DATA_BYTES-1:0] keep_o,
   output logic                  last_o
);

   localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(DATA_BYTES);

   logic [LEN_W-1:0] cap_s;
   logic [LEN_W-1:0] n_s;

   // n = min(beat width, total_rem, frame_rem when framing is enabled)
   always_comb begin
      cap_s = (total_rem_i < BEAT_BYTES) ? total_rem_i : BEAT_BYTES;
      if (frame_en_i && (frame_rem_i < cap_s)) begin
         n_s = frame_rem_i;
      end else begin
         n_s = cap_s;
      end
      keep_o = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         keep_o[i] = (LEN_W'(i) < n_s);
      end
      last_o = (n_s == total_rem_i) || (frame_en_i && (n_s == frame_rem_i));
   end

   assign n_o = n_s;

endmodule

// File: rtl/aurora_hls_tx_framer.sv
// Splits a byte-counted stream into frames for the Aurora TX FIFO, one output beat per input beat.
module aurora_hls_tx_framer
   import aurora_hls_pkg::*;
#(
   parameter int DATA_BYTES = DATA_BYTES_DEF,
   parameter int LEN_W      = LEN_W_DEF
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic [LEN_W-1:0]        cfg_transfer_bytes,
   input  logic [LEN_W-1:0]        cfg_frame_bytes,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [LEN_W-1:0]        frame_count,
   input  logic                    fifo_tx_prog_full,
   aurora_hls_tx_framer_if.slave   s_axis,
   aurora_hls_tx_framer_if.master  m_axis
);

   state_e                  state_q, state_d;
   logic [LEN_W-1:0]        total_rem_q, total_rem_d;
   logic [LEN_W-1:0]        frame_rem_q, frame_rem_d;
   logic [LEN_W-1:0]        frame_bytes_q, frame_bytes_d;
   logic [LEN_W-1:0]        frame_count_q, frame_count_d;
   logic                    m_tvalid_q, m_tvalid_d;
   logic [DATA_BYTES*8-1:0] m_tdata_q, m_tdata_d;
   logic [DATA_BYTES-1:0]   m_tkeep_q, m_tkeep_d;
   logic                    m_tlast_q, m_tlast_d;

   logic                    frame_en_s;
   logic                    s_ready_s;
   logic                    accept_s;
   logic [LEN_W-1:0]        n_s;
   logic [DATA_BYTES-1:0]   keep_s;
   logic                    last_s;
   logic [DATA_BYTES*8-1:0] masked_s;

   assign frame_en_s = (frame_bytes_q != '0);
   // prog_full only gates new acceptance; a pending output beat stays valid
   assign s_ready_s  = (state_q == ST_RUN) && (total_rem_q != '0) && !fifo_tx_prog_full
                       && (!m_tvalid_q || m_axis.tready);
   assign accept_s   = s_ready_s && s_axis.tvalid;

   aurora_hls_keep_gen #(
      .DATA_BYTES (DATA_BYTES),
      .LEN_W      (LEN_W)
   ) u_keep_gen (
      .total_rem_i (total_rem_q),
      .frame_rem_i (frame_rem_q),
      .frame_en_i  (frame_en_s),
      .n_o         (n_s),
      .keep_o      (keep_s),
      .last_o      (last_s)
   );

   // Bytes above n are zeroed so nothing spills into the next beat
   always_comb begin
      masked_s = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         masked_s[i*8 +: 8] = keep_s[i] ? s_axis.tdata[i*8 +: 8] : 8'h00;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d       = state_q;
      total_rem_d   = total_rem_q;
      frame_rem_d   = frame_rem_q;
      frame_bytes_d = frame_bytes_q;
      frame_count_d = frame_count_q;
      m_tvalid_d    = m_tvalid_q;
      m_tdata_d     = m_tdata_q;
      m_tkeep_d     = m_tkeep_q;
      m_tlast_d     = m_tlast_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               total_rem_d   = cfg_transfer_bytes;
               frame_rem_d   = cfg_frame_bytes;
               frame_bytes_d = cfg_frame_bytes;
               frame_count_d = '0;
               state_d       = (cfg_transfer_bytes == '0) ? ST_DONE : ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s) begin
               m_tvalid_d  = 1'b1;
               m_tdata_d   = masked_s;
               m_tkeep_d   = keep_s;
               m_tlast_d   = last_s;
               total_rem_d = total_rem_q - n_s;
               if (last_s || !frame_en_s) begin
                  frame_rem_d = frame_bytes_q;
               end else begin
                  frame_rem_d = frame_rem_q - n_s;
               end
               if (last_s) begin
                  frame_count_d = frame_count_q + LEN_W'(1);
               end else begin
                  frame_count_d = frame_count_q;
               end
            end else if (m_tvalid_q && m_axis.tready) begin
               m_tvalid_d = 1'b0;
               if (total_rem_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               m_tvalid_d = m_tvalid_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q       <= ST_IDLE;
         total_rem_q   <= '0;
         frame_rem_q   <= '0;
         frame_bytes_q <= '0;
         frame_count_q <= '0;
         m_tvalid_q    <= 1'b0;
         m_tdata_q     <= '0;
         m_tkeep_q     <= '0;
         m_tlast_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         total_rem_q   <= total_rem_d;
         frame_rem_q   <= frame_rem_d;
         frame_bytes_q <= frame_bytes_d;
         frame_count_q <= frame_count_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tdata_q     <= m_tdata_d;
         m_tkeep_q     <= m_tkeep_d;
         m_tlast_q     <= m_tlast_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);
   assign frame_count   = frame_count_q;
   assign s_axis.tready = s_ready_s;
   assign m_axis.tvalid = m_tvalid_q;
   assign m_axis.tdata  = m_tdata_q;
   assign m_axis.tkeep  = m_tkeep_q;
   assign m_axis.tlast  = m_tlast_q;

endmodule

// File: tb/tb_aurora_hls_tx_framer.sv
// Self-checking bench for aurora_hls_tx_framer against a byte-position reference model.
module tb_aurora_hls_tx_framer;

   localparam int DB = 64;
   localparam int LW = 32;

   typedef struct packed {
      logic [DB*8-1:0] data;
      logic [DB-1:0]   keep;
      logic            last;
   } beat_t;

   logic          ap_clk = 1'b0;
   logic          ap_rst = 1'b1;
   logic [LW-1:0] cfg_transfer_bytes = '0;
   logic [LW-1:0] cfg_frame_bytes = '0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [LW-1:0] frame_count;
   logic          fifo_tx_prog_full = 1'b0;

   aurora_hls_tx_framer_if #(.DATA_BYTES(DB)) s_if ();
   aurora_hls_tx_framer_if #(.DATA_BYTES(DB)) m_if ();

   aurora_hls_tx_framer #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
      .ap_clk             (ap_clk),
      .ap_rst             (ap_rst),
      .cfg_transfer_bytes (cfg_transfer_bytes),
      .cfg_frame_bytes    (cfg_frame_bytes),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .frame_count        (frame_count),
      .fifo_tx_prog_full  (fifo_tx_prog_full),
      .s_axis             (s_if),
      .m_axis             (m_if)
   );

   always #5 ap_clk = ~ap_clk;

   int n_cmp = 0;
   int n_fail = 0;

   logic [DB*8-1:0] in_q[$];
   beat_t           obs_q[$];
   beat_t           exp_q[$];
   int              exp_frames;
   int              done_cyc, last_take_cyc, done_cnt, pf_viol, stab_viol;
   logic [LW-1:0]   fc_end;
   logic            busy_end;
   bit              timed_out;

   function automatic logic [DB*8-1:0] rnd_data();
      logic [DB*8-1:0] r;
      for (int i = 0; i < DB/4; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference: walk byte positions; a beat ends at the beat width, a frame boundary or the transfer end.
   function automatic void build_exp(input int t_bytes, input int f_bytes);
      int p, n, k;
      beat_t b;
      logic [DB*8-1:0] d;
      exp_q.delete();
      exp_frames = 0;
      p = 0;
      while (p < t_bytes) begin
         n = (t_bytes - p < DB) ? (t_bytes - p) : DB;
         if (f_bytes != 0 && (f_bytes - (p % f_bytes)) < n) n = f_bytes - (p % f_bytes);
         k = exp_q.size();
         d = (k < in_q.size()) ? in_q[k] : '0;
         b = '0;
         for (int j = 0; j < n; j++) begin
            b.keep[j] = 1'b1;
            b.data[j*8 +: 8] = d[j*8 +: 8];
         end
         b.last = (p + n == t_bytes) || (f_bytes != 0 && ((p + n) % f_bytes) == 0);
         if (b.last) exp_frames++;
         exp_q.push_back(b);
         p += n;
      end
   endfunction

   task automatic run_transfer(input int t_bytes, input int f_bytes, input bit rand_hs,
                               input int pf_start, input int pf_len, input int rdy_low_len,
                               input bit poke_start);
      beat_t cur, prev_m;
      bit    prev_stall, s_acc;
      obs_q.delete(); in_q.delete();
      done_cyc = -1; last_take_cyc = -1; done_cnt = 0; pf_viol = 0; stab_viol = 0; timed_out = 0;
      prev_m = '0;
      @(negedge ap_clk);
      cfg_transfer_bytes = t_bytes; cfg_frame_bytes = f_bytes; start = 1'b1;
      s_if.tvalid = 1'b0; m_if.tready = 1'b1;
      @(negedge ap_clk);
      start = 1'b0; cfg_transfer_bytes = $urandom; cfg_frame_bytes = $urandom;
      s_acc = 1'b1; prev_stall = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) @(negedge ap_clk);
         if (s_acc || !s_if.tvalid) begin
            s_if.tvalid = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            s_if.tdata  = rnd_data();
         end
         fifo_tx_prog_full = (cyc >= pf_start) && (cyc < pf_start + pf_len);
         m_if.tready = (cyc >= pf_start && cyc < pf_start + rdy_low_len) ? 1'b0 :
                       (rand_hs ? 1'($urandom_range(0, 1)) : 1'b1);
         start = poke_start && (done_cyc < 0) && ((cyc % 7) == 2);
         #1;
         if (fifo_tx_prog_full && s_if.tready) pf_viol++;
         cur = {m_if.tdata, m_if.tkeep, m_if.tlast};
         if (prev_stall && (!m_if.tvalid || cur !== prev_m)) stab_viol++;
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_m = cur;
         s_acc = s_if.tvalid && s_if.tready;
         if (s_acc) in_q.push_back(s_if.tdata);
         if (m_if.tvalid && m_if.tready) begin
            obs_q.push_back(cur);
            last_take_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               fc_end = frame_count;
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      if (done_cyc < 0) timed_out = 1'b1;
      busy_end = busy;
      start = 1'b0; fifo_tx_prog_full = 1'b0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({busy, done, frame_count, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, s_if.tready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b fc=%0d mv=%b ml=%b mk=%h sr=%b, want all zero",
                  busy, done, frame_count, m_if.tvalid, m_if.tlast, m_if.tkeep, s_if.tready);
      end
      repeat (2) @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk); #1;
      n_cmp++;
      if ({busy, done, m_if.tvalid, s_if.tready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b done=%b mv=%b sr=%b, want 0000", busy, done, m_if.tvalid, s_if.tready);
      end
   endtask

   task automatic test_frames_256_128();
      run_transfer(256, 128, 1'b0, 10000, 0, 0, 1'b0);
      build_exp(256, 128);
      n_cmp++;
      if (timed_out || obs_q.size() != 4 || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL f256 beats: got %0d want 4 (timeout=%0d)", obs_q.size(), timed_out);
      end
      foreach (obs_q[k]) if (k < exp_q.size()) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL f256 beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
      n_cmp++;
      if (fc_end !== 32'd2) begin n_fail++; $display("FAIL f256 frame_count: got %0d want 2", fc_end); end
      n_cmp++;
      if (done_cyc != last_take_cyc + 1 || done_cnt != 1) begin
         n_fail++; $display("FAIL f256 done_timing: got done@%0d x%0d want @%0d x1", done_cyc, done_cnt, last_take_cyc + 1);
      end
      n_cmp++;
      if (busy_end !== 1'b0) begin n_fail++; $display("FAIL f256 busy_end: got %b want 0", busy_end); end
   endtask

   task automatic test_single_frame_200();
      run_transfer(200, 0, 1'b0, 10000, 0, 0, 1'b0);
      build_exp(200, 0);
      n_cmp++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL f200 beats: got %0d want %0d (timeout=%0d)", obs_q.size(), exp_q.size(), timed_out);
      end
      foreach (obs_q[k]) if (k < exp_q.size()) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL f200 beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
      if (obs_q.size() == 4) begin
         n_cmp++;
         if (obs_q[3].keep !== 64'h0000_0000_0000_00FF || obs_q[3].last !== 1'b1) begin
            n_fail++; $display("FAIL f200 last_keep: got %h/%b want 00000000000000ff/1", obs_q[3].keep, obs_q[3].last);
         end
      end
      n_cmp++;
      if (fc_end !== 32'd1) begin n_fail++; $display("FAIL f200 frame_count: got %0d want 1", fc_end); end
   endtask

   task automatic test_frame_40();
      run_transfer(100, 40, 1'b0, 10000, 0, 0, 1'b0);
      build_exp(100, 40);
      n_cmp++;
      if (timed_out || obs_q.size() != 3) begin
         n_fail++; $display("FAIL f40 beats: got %0d want 3 (timeout=%0d)", obs_q.size(), timed_out);
      end
      foreach (obs_q[k]) if (k < exp_q.size()) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL f40 beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
      n_cmp++;
      if (fc_end !== 32'd3) begin n_fail++; $display("FAIL f40 frame_count: got %0d want 3", fc_end); end
   endtask

   task automatic test_prog_full();
      run_transfer(640, 192, 1'b0, 3, 10, 5, 1'b0);
      build_exp(640, 192);
      n_cmp++;
      if (pf_viol != 0) begin n_fail++; $display("FAIL pf s_tready: got %0d cycles high want 0", pf_viol); end
      n_cmp++;
      if (stab_viol != 0) begin n_fail++; $display("FAIL pf stability: got %0d changes want 0", stab_viol); end
      n_cmp++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL pf beats: got %0d want %0d (timeout=%0d)", obs_q.size(), exp_q.size(), timed_out);
      end
      foreach (obs_q[k]) if (k < exp_q.size()) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL pf beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
      n_cmp++;
      if (fc_end !== 32'(exp_frames)) begin n_fail++; $display("FAIL pf frame_count: got %0d want %0d", fc_end, exp_frames); end
   endtask

   task automatic test_random_stall_start();
      int t, f;
      for (int it = 0; it < 4; it++) begin
         t = $urandom_range(1, 900);
         f = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(16, 200);
         run_transfer(t, f, 1'b1, 10000, 0, 0, 1'b1);
         build_exp(t, f);
         n_cmp++;
         if (timed_out || obs_q.size() != exp_q.size() || done_cnt != 1) begin
            n_fail++; $display("FAIL rnd%0d beats: got %0d want %0d (t=%0d f=%0d timeout=%0d done=%0d)",
                               it, obs_q.size(), exp_q.size(), t, f, timed_out, done_cnt);
         end
         foreach (obs_q[k]) if (k < exp_q.size()) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd%0d beat%0d: got %h want %h", it, k, obs_q[k], exp_q[k]); end
         end
         n_cmp++;
         if (stab_viol != 0 || fc_end !== 32'(exp_frames)) begin
            n_fail++; $display("FAIL rnd%0d stab/fc: got %0d/%0d want 0/%0d", it, stab_viol, fc_end, exp_frames);
         end
      end
   endtask

   task automatic test_reset_mid();
      int viol;
      @(negedge ap_clk);
      cfg_transfer_bytes = 512; cfg_frame_bytes = 0; start = 1'b1;
      s_if.tvalid = 1'b1; s_if.tdata = rnd_data(); m_if.tready = 1'b0;
      @(negedge ap_clk);
      start = 1'b0;
      repeat (3) @(negedge ap_clk);
      #2 ap_rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, frame_count, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, s_if.tready} !== '0) begin
         n_fail++; $display("FAIL midrst_async: got busy=%b mv=%b mk=%h sr=%b, want all zero", busy, m_if.tvalid, m_if.tkeep, s_if.tready);
      end
      @(negedge ap_clk); #1;
      n_cmp++;
      if ({busy, done, frame_count, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, s_if.tready} !== '0) begin
         n_fail++; $display("FAIL midrst_held: got busy=%b mv=%b mk=%h sr=%b, want all zero", busy, m_if.tvalid, m_if.tkeep, s_if.tready);
      end
      ap_rst = 1'b0; m_if.tready = 1'b1;
      viol = 0;
      repeat (5) begin
         @(negedge ap_clk); #1;
         if (m_if.tvalid || busy || s_if.tready) viol++;
      end
      n_cmp++;
      if (viol != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles want 0", viol); end
      @(negedge ap_clk);
      cfg_transfer_bytes = 0; cfg_frame_bytes = $urandom; start = 1'b1;
      @(negedge ap_clk);
      start = 1'b0;
      #1;
      n_cmp++;
      if ({done, busy, m_if.tvalid, frame_count} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
         n_fail++; $display("FAIL zero_done: got done=%b busy=%b mv=%b fc=%0d want 1 1 0 0", done, busy, m_if.tvalid, frame_count);
      end
      @(negedge ap_clk); #1;
      n_cmp++;
      if ({done, busy, m_if.tvalid} !== 3'b000) begin
         n_fail++; $display("FAIL zero_after: got done=%b busy=%b mv=%b want 000", done, busy, m_if.tvalid);
      end
      s_if.tvalid = 1'b0;
   endtask

   initial begin
      s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tkeep = '0;
      m_if.tready = 1'b1;
      test_reset();
      test_frames_256_128();
      test_single_frame_200();
      test_frame_40();
      test_prog_full();
      test_random_stall_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no completion by 3 ms want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
